// File: rtl/step_scheduler_if.sv
// rtl/step_scheduler_if.sv - transport/pattern bus between the controller and the step scheduler
interface step_scheduler_if #(
  parameter int PERIOD_W = 24
);
  logic                start;
  logic                pause;
  logic                stop;
  logic [PERIOD_W-1:0] step_period;
  logic [PERIOD_W-1:0] gate_len;
  logic [3:0]          seq_len;
  logic [2:0]          beats [0:15];
  logic [3:0]          beat_index;
  logic [2:0]          pitch;
  logic                gate;
  logic                step_tick;
  logic                running;

  modport master (
    output start, pause, stop, step_period, gate_len, seq_len, beats,
    input  beat_index, pitch, gate, step_tick, running
  );

  modport slave (
    input  start, pause, stop, step_period, gate_len, seq_len, beats,
    output beat_index, pitch, gate, step_tick, running
  );
endinterface

// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - step sequencer walking a 16-step pitch pattern at a programmable tempo
module step_scheduler #(
  parameter int PERIOD_W   = 24,
  parameter int MIN_PERIOD = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  step_scheduler_if.slave      bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_e;

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

  state_e              state_q, state_d;
  logic [3:0]          beat_index_q, beat_index_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] per_eff_q, per_eff_d;
  logic [PERIOD_W-1:0] gate_eff_q, gate_eff_d;
  logic [2:0]          pitch_q, pitch_d;
  logic                gate_q, gate_d;
  logic                step_tick_q, step_tick_d;
  logic                running_q, running_d;

  logic [PERIOD_W-1:0] per_new, gate_new;
  logic [3:0]          idx_next, entry_idx;
  logic                do_entry, do_clear;

  always_comb begin
    per_new  = (bus.step_period < MIN_P) ? MIN_P : bus.step_period;
    gate_new = (bus.gate_len > per_new - ONE) ? per_new - ONE : bus.gate_len;
    // Compare against the live seq_len so a shortened loop wraps at the next boundary
    idx_next = (beat_index_q >= bus.seq_len) ? 4'd0 : beat_index_q + 4'd1;
  end

  always_comb begin
    state_d      = state_q;
    beat_index_d = beat_index_q;
    phase_d      = phase_q;
    per_eff_d    = per_eff_q;
    gate_eff_d   = gate_eff_q;
    pitch_d      = pitch_q;
    gate_d       = gate_q;
    step_tick_d  = 1'b0;
    do_entry     = 1'b0;
    do_clear     = 1'b0;
    entry_idx    = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (!bus.stop && bus.start) begin
          state_d  = S_RUN;
          do_entry = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          do_clear = 1'b1;
        end else if (bus.pause) begin
          state_d = S_PAUSED;
          gate_d  = 1'b0;
        end else if (phase_q == per_eff_q - ONE) begin
          do_entry  = 1'b1;
          entry_idx = idx_next;
        end else begin
          phase_d = phase_q + ONE;
          if (phase_q + ONE == gate_eff_q) gate_d = 1'b0;
        end
      end
      S_PAUSED: begin
        if (bus.stop) begin
          do_clear = 1'b1;
        end else if (bus.start) begin
          state_d = S_RUN;
          gate_d  = (pitch_q != 3'd0) && (phase_q < gate_eff_q);
        end
      end
      default: do_clear = 1'b1;
    endcase

    if (do_entry) begin
      beat_index_d = entry_idx;
      phase_d      = '0;
      step_tick_d  = 1'b1;
      pitch_d      = bus.beats[entry_idx];
      per_eff_d    = per_new;
      gate_eff_d   = gate_new;
      gate_d       = (bus.beats[entry_idx] != 3'd0) && (gate_new != '0);
    end

    if (do_clear) begin
      state_d      = S_IDLE;
      beat_index_d = 4'd0;
      phase_d      = '0;
      per_eff_d    = '0;
      gate_eff_d   = '0;
      pitch_d      = 3'd0;
      gate_d       = 1'b0;
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_index_q <= 4'd0;
      phase_q      <= '0;
      per_eff_q    <= '0;
      gate_eff_q   <= '0;
      pitch_q      <= 3'd0;
      gate_q       <= 1'b0;
      step_tick_q  <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_index_q <= beat_index_d;
      phase_q      <= phase_d;
      per_eff_q    <= per_eff_d;
      gate_eff_q   <= gate_eff_d;
      pitch_q      <= pitch_d;
      gate_q       <= gate_d;
      step_tick_q  <= step_tick_d;
      running_q    <= running_d;
    end
  end

  assign bus.beat_index = beat_index_q;
  assign bus.pitch      = pitch_q;
  assign bus.gate       = gate_q;
  assign bus.step_tick  = step_tick_q;
  assign bus.running    = running_q;
endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - directed self-checking bench for step_scheduler
module tb_step_scheduler;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [2:0] pat [0:15];

  step_scheduler_if #(.PERIOD_W(24)) bus ();

  step_scheduler #(.PERIOD_W(24), .MIN_PERIOD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, bus.beat_index, bus.pitch, bus.gate, bus.step_tick, bus.running};
  endfunction

  function automatic logic [31:0] pack(input int idx, input int p, input bit g, input bit t, input bit r);
    logic [3:0] i4;
    logic [2:0] p3;
    i4 = 4'(idx);
    p3 = 3'(p);
    return {23'd0, i4, p3, g, t, r};
  endfunction

  // Expected outputs at cycle c counted from the step-0 entry cycle
  task automatic trace(input int ncyc, input int c0, input int per, input int glen, input int last);
    int pe, ge, c, ph, idx;
    pe = (per < 2) ? 2 : per;
    ge = (glen > pe - 1) ? pe - 1 : glen;
    for (int i = 0; i < ncyc; i++) begin
      c   = c0 + i;
      ph  = c % pe;
      idx = (c / pe) % (last + 1);
      check($sformatf("trace c%0d", c), outs(),
            pack(idx, pat[idx], (pat[idx] != 0) && (ph < ge), ph == 0, 1'b1));
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic set_cfg(input int per, input int glen, input int last);
    bus.step_period = 24'(per);
    bus.gate_len    = 24'(glen);
    bus.seq_len     = 4'(last);
  endtask

  initial begin
    int init_pat [0:15] = '{5, 0, 7, 1, 2, 3, 4, 6, 1, 0, 5, 7, 2, 3, 4, 6};
    for (int i = 0; i < 16; i++) begin
      pat[i]       = 3'(init_pat[i]);
      bus.beats[i] = 3'(init_pat[i]);
    end
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(4, 2, 3);
    repeat (2) @(negedge clk);
    check("reset outs", outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle outs", outs(), 32'd0);

    // Basic loop: 4-cycle steps, 2-cycle gate, steps 0..3
    pulse_start();
    trace(20, 0, 4, 2, 3);
    pulse_stop();
    check("stop clears", outs(), 32'd0);

    // Period clamp to 2, gate clamp to 1
    set_cfg(1, 9, 3);
    pulse_start();
    trace(12, 0, 1, 9, 3);
    pulse_stop();

    // Pause at phase 3 of step 2, hold 20 cycles, resume
    set_cfg(8, 5, 3);
    pulse_start();
    trace(19, 0, 8, 5, 3);
    bus.pause = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("paused %0d", i), outs(), pack(2, 7, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
    end
    pulse_start();
    trace(13, 19, 8, 5, 3);
    pulse_stop();

    // Same-cycle command priority
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start+stop idle", outs(), 32'd0);
    @(negedge clk);
    check("still idle", outs(), 32'd0);
    pulse_start();
    trace(10, 0, 8, 5, 3);
    bus.pause = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    check("pause+stop run", outs(), 32'd0);

    // seq_len lowered below current index, then mid-step pattern write
    set_cfg(4, 2, 15);
    pulse_start();
    trace(37, 0, 4, 2, 15);
    bus.seq_len = 4'd4;
    repeat (3) @(negedge clk);
    check("wrap to 0", outs(), pack(0, 5, 1'b1, 1'b1, 1'b1));
    @(negedge clk);
    bus.beats[0] = 3'd3;
    @(negedge clk);
    check("pitch held", {29'd0, bus.pitch}, 32'd5);
    repeat (2) @(negedge clk);
    check("step 1 after wrap", outs(), pack(1, 0, 1'b0, 1'b1, 1'b1));
    repeat (16) @(negedge clk);
    check("new pitch step 0", outs(), pack(0, 3, 1'b1, 1'b1, 1'b1));
    bus.beats[0] = 3'd5;
    pulse_stop();

    // Asynchronous reset mid-gate at step 6
    set_cfg(4, 2, 15);
    pulse_start();
    trace(24, 0, 4, 2, 15);
    check("gate pre-reset", {31'd0, bus.gate}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async reset", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle after reset", outs(), 32'd0);
    pulse_start();
    check("restart", outs(), pack(0, 5, 1'b1, 1'b1, 1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
